// File: rtl/calc_pkg.sv
// Shared definitions for the calculator input controller: sizes, ASCII
// codes, the evaluator state encoding and small helper functions.
package calc_pkg;

  localparam int BUF_LEN = 32;
  localparam int RES_W   = 32;
  localparam int IDX_W   = $clog2(BUF_LEN);      // char index width
  localparam int LEN_W   = $clog2(BUF_LEN + 1);  // len counts 0..BUF_LEN

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(BUF_LEN);

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_MUL   = 8'h2A;
  localparam logic [7:0] CH_C     = 8'h43;
  localparam logic [7:0] CH_B     = 8'h42;
  localparam logic [7:0] CH_EQ    = 8'h3D;

  typedef enum logic [1:0] {IDLE, EVAL, FINISH} eval_state_t;

  // Keypad legend at (row, col), row-major 4x4 grid.
  function automatic logic [7:0] key_char(input logic [1:0] row, input logic [1:0] col);
    logic [7:0] ch;
    case ({row, col})
      4'd0:    ch = 8'h31;
      4'd1:    ch = 8'h32;
      4'd2:    ch = 8'h33;
      4'd3:    ch = CH_PLUS;
      4'd4:    ch = 8'h34;
      4'd5:    ch = 8'h35;
      4'd6:    ch = 8'h36;
      4'd7:    ch = CH_MINUS;
      4'd8:    ch = 8'h37;
      4'd9:    ch = 8'h38;
      4'd10:   ch = 8'h39;
      4'd11:   ch = CH_MUL;
      4'd12:   ch = CH_C;
      4'd13:   ch = CH_0;
      4'd14:   ch = CH_EQ;
      default: ch = CH_B;
    endcase
    return ch;
  endfunction

  function automatic logic is_digit(input logic [7:0] ch);
    return (ch >= CH_0) && (ch <= CH_9);
  endfunction

  function automatic logic is_op(input logic [7:0] ch);
    return (ch == CH_PLUS) || (ch == CH_MINUS) || (ch == CH_MUL);
  endfunction

  // One step of left-to-right evaluation, modulo 2^RES_W.
  function automatic logic [RES_W-1:0] apply_op(input logic [RES_W-1:0] acc,
                                                input logic [7:0]       op,
                                                input logic [RES_W-1:0] num);
    logic [RES_W-1:0] res;
    case (op)
      CH_MINUS: res = acc - num;
      CH_MUL:   res = acc * num;
      default:  res = acc + num;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/calc_input_ctrl_if.sv
// Keypad pulses in, renderer-facing cursor/string/result out.
interface calc_input_ctrl_if;
  import calc_pkg::*;

  logic                 btn_up;
  logic                 btn_down;
  logic                 btn_left;
  logic                 btn_right;
  logic                 btn_sel;
  logic [3:0]           cursor_x;
  logic [3:0]           cursor_y;
  logic [BUF_LEN*8-1:0] disp_str_flat;
  logic [RES_W-1:0]     result;
  logic                 calc_done;
  logic                 busy;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_sel,
    input  cursor_x, cursor_y, disp_str_flat, result, calc_done, busy
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_sel,
    output cursor_x, cursor_y, disp_str_flat, result, calc_done, busy
  );

endinterface

// File: rtl/calc_eval.sv
// Sequential expression evaluator: walks the buffer one char per cycle,
// strict left-to-right with no precedence, then publishes the result.
module calc_eval
  import calc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 clr_done,
  input  logic [LEN_W-1:0]     len,
  input  logic [BUF_LEN*8-1:0] buf_flat,
  output logic                 busy,
  output logic                 done,
  output logic [RES_W-1:0]     result
);

  eval_state_t      state_reg, state_next;
  logic [LEN_W-1:0] idx_reg;
  logic [RES_W-1:0] acc_reg;
  logic [RES_W-1:0] num_reg;
  logic [7:0]       op_reg;
  logic [7:0]       ch;
  logic             last_char;

  assign ch        = buf_flat[{idx_reg[IDX_W-1:0], 3'b000} +: 8];
  assign last_char = ((idx_reg + LEN_W'(1)) == len);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; an empty buffer goes straight to FINISH.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = (len == '0) ? FINISH : EVAL;
      EVAL:    if (last_char) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: accumulator, operand, pending operator and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_reg <= '0;
      acc_reg <= '0;
      num_reg <= '0;
      op_reg  <= CH_PLUS;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            idx_reg <= '0;
            acc_reg <= '0;
            num_reg <= '0;
            op_reg  <= CH_PLUS;
            busy    <= 1'b1;
            done    <= 1'b0;
          end else if (clr_done) begin
            done    <= 1'b0;
          end
        end
        EVAL: begin
          idx_reg <= idx_reg + LEN_W'(1);
          if (is_digit(ch)) begin
            num_reg <= num_reg * RES_W'(10) + RES_W'(ch - CH_0);
          end else begin
            acc_reg <= apply_op(acc_reg, op_reg, num_reg);
            num_reg <= '0;
            op_reg  <= ch;
          end
        end
        FINISH: begin
          result <= apply_op(acc_reg, op_reg, num_reg);
          done   <= 1'b1;
          busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/calc_input_ctrl.sv
// Calculator keypad controller: cursor navigation, expression buffer
// editing and select decode; evaluation is delegated to calc_eval.
module calc_input_ctrl
  import calc_pkg::*;
(
  input  logic              clk_in,
  input  logic              sys_rst,
  calc_input_ctrl_if.slave  bus
);

  logic [1:0]           cx_reg;
  logic [1:0]           cy_reg;
  logic [7:0]           buf_reg [BUF_LEN];
  logic [LEN_W-1:0]     len_reg;
  logic [LEN_W-1:0]     len_dec;
  logic [BUF_LEN*8-1:0] buf_flat;
  logic [7:0]           key;
  logic                 sel_ok;
  logic                 start;
  logic                 eval_busy;
  logic                 eval_done;
  logic [RES_W-1:0]     eval_result;

  // Select decode: the key under the cursor, gated off while evaluating.
  always_comb begin
    key     = key_char(cy_reg, cx_reg);
    sel_ok  = bus.btn_sel & ~eval_busy;
    start   = sel_ok & (key == CH_EQ);
    len_dec = len_reg - LEN_W'(1);
  end

  // Cursor moves: select beats moves, then up > down > left > right; wraps mod 4.
  always_ff @(posedge clk_in or posedge sys_rst) begin
    if (sys_rst) begin
      cx_reg <= '0;
      cy_reg <= '0;
    end else if (!eval_busy && !bus.btn_sel) begin
      if (bus.btn_up)         cy_reg <= cy_reg - 2'd1;
      else if (bus.btn_down)  cy_reg <= cy_reg + 2'd1;
      else if (bus.btn_left)  cx_reg <= cx_reg - 2'd1;
      else if (bus.btn_right) cx_reg <= cx_reg + 2'd1;
    end
  end

  // Buffer edits: append digit/operator, backspace, clear.
  always_ff @(posedge clk_in or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < BUF_LEN; i++) buf_reg[i] <= CH_SPACE;
      len_reg <= '0;
    end else if (sel_ok) begin
      if (is_digit(key) || is_op(key)) begin
        if (len_reg < LEN_MAX) begin
          buf_reg[len_reg[IDX_W-1:0]] <= key;
          len_reg <= len_reg + LEN_W'(1);
        end
      end else if (key == CH_B) begin
        if (len_reg != '0) begin
          buf_reg[len_dec[IDX_W-1:0]] <= CH_SPACE;
          len_reg <= len_dec;
        end
      end else if (key == CH_C) begin
        for (int i = 0; i < BUF_LEN; i++) buf_reg[i] <= CH_SPACE;
        len_reg <= '0;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < BUF_LEN; gi++) begin : g_flat
      assign buf_flat[gi*8 +: 8] = buf_reg[gi];
    end
  endgenerate

  calc_eval u_eval (
    .clk      (clk_in),
    .rst      (sys_rst),
    .start    (start),
    .clr_done (sel_ok),
    .len      (len_reg),
    .buf_flat (buf_flat),
    .busy     (eval_busy),
    .done     (eval_done),
    .result   (eval_result)
  );

  assign bus.cursor_x      = {2'b00, cx_reg};
  assign bus.cursor_y      = {2'b00, cy_reg};
  assign bus.disp_str_flat = buf_flat;
  assign bus.result        = eval_result;
  assign bus.calc_done     = eval_done;
  assign bus.busy          = eval_busy;

endmodule

// File: doc/calc_input_ctrl.md
# calc_input_ctrl

Keypad-side controller for the on-screen calculator and the producer of the signals the LCD picture generator consumes. It turns debounced navigation/select pulses into a 4×4 cursor position and maintains a 32-character expression buffer. When '=' is selected it evaluates the buffer sequentially into a 32-bit result. Its outputs drive the renderer's cursor, string, result and done inputs directly.

## Interface
- BUF_LEN, 32, expression buffer length in characters.
- RES_W, 32, result width in bits.

- clk_in  input  1  system clock.
- sys_rst  input  1  asynchronous, active-high reset.
- btn_up / btn_down / btn_left / btn_right  input  1 each  single-cycle, debounced move pulses.
- btn_sel  input  1  single-cycle select pulse.
- cursor_x  output  4  cursor column, 0..3.
- cursor_y  output  4  cursor row, 0..3.
- disp_str_flat  output  BUF_LEN*8  ASCII buffer; char k at bits [k*8 +: 8].
- result  output  RES_W  last evaluated value, unsigned.
- calc_done  output  1  high while result is valid for the current buffer.
- busy  output  1  high during evaluation.

## Operation
- Key map, row-major (y,x): row0 "1 2 3 +", row1 "4 5 6 -", row2 "7 8 9 *", row3 "C 0 = B".
- Moves: cursor_x and cursor_y wrap modulo 4 (left at x=0 goes to x=3; down at y=3 goes to y=0).
- Same-cycle pulses: btn_sel wins and all moves are ignored. Among moves, priority is up > down > left > right, and only one move is applied.
- While busy, every input pulse is ignored.
- Select on a digit or operator: write the char at index len and increment len. If len == BUF_LEN, the press is ignored.
- Select on 'B': if len > 0, decrement len and write 0x20 at the new len.
- Select on 'C': fill the buffer with 0x20 and set len = 0.
- Any select clears calc_done. '=' is never stored in the buffer.
- Select on '=': set calc_done=0, busy=1, then run the evaluator.
- Evaluator FSM states:
  - IDLE: waits for '='.
  - EVAL: processes one char per cycle, index 0..len-1.
  - FINISH: applies the pending op, writes result, sets calc_done=1 and busy=0, returns to IDLE.
- Evaluation rules:
  - Strict left-to-right evaluation, no precedence.
  - acc starts at 0 and the pending op starts as '+'.
  - Digit: num = num*10 + d.
  - Operator: acc = acc (pending op) num, num = 0, pending op = this operator.
  - Empty operands count as 0, so a leading, trailing or doubled operator uses 0.
- Arithmetic is RES_W-bit unsigned modulo 2^RES_W: subtraction wraps and products are truncated to the low RES_W bits.
- result holds its old value until FINISH.

## Timing
- Reset values:
  - cursor_x = cursor_y = 0
  - every disp_str_flat char = 0x20
  - result = 0, calc_done = 0, busy = 0
  - len = 0, FSM in IDLE
- All outputs are registered.
- A move or edit pulse sampled at edge T is visible after edge T.
- '=' sampled at edge T:
  - busy=1 and calc_done=0 after T.
  - EVAL occupies len cycles, then one FINISH cycle.
  - result and calc_done=1 (with busy=0) appear after edge T+len+1; with len=0 this is after T+1.
- sys_rst asserted mid-evaluation aborts it and restores all reset values. No partial result is ever published.
- The buffer is stable during EVAL because edits are blocked.

## Structure
- Shared package calc_pkg holds:
  - the key-map function key_char(row, col);
  - ASCII constants for space, '0', '+', '-', '*', 'C', 'B', '=';
  - the evaluator state enum {IDLE, EVAL, FINISH};
  - BUF_LEN.
- Sub-module calc_eval contains the evaluator FSM, acc/num/pending-op registers and the char index. It has start/busy/done handshake signals and reads the buffer and len from the parent.
- The top level holds the cursor, the buffer, len and select decode.

## Test plan
- After reset: cursor (0,0), all chars 0x20, result=0, calc_done=0. Pulse left once -> cursor_x=3. Pulse up once -> cursor_y=3.
- Enter "12+3*4", then '=' -> buffer shows "12+3*4", busy is high for 7 cycles, then result=60 and calc_done=1.
- Enter "3-5", then '=' -> result=4294967294.
- Press '1' 33 times -> len=32, the 33rd press is ignored. Press 'B' -> char 31 becomes 0x20. Press 'C' -> buffer all 0x20.
- Enter "+*7", then '=' -> result=0. Enter '=' on an empty buffer -> result=0 and calc_done=1 after 1 cycle.
- Assert sys_rst two cycles into evaluating "99*99" -> all outputs return to reset values, and result stays 0.
- Pulse btn_sel and btn_right in the same cycle -> only the select takes effect and the cursor does not move.
